// File: rtl/xor8_if.sv
// Operand/result bundle for the xor8 block; the parity wire exists only
// when XOR8_PARITY_EN is defined.
interface xor8_if #(
    parameter int WIDTH = 8
);
    localparam int ONES_W = $clog2(WIDTH + 1);

    logic              in_valid;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [WIDTH-1:0]  Z;
    logic              out_valid;
    logic              zero;
    logic [ONES_W-1:0] ones;
`ifdef XOR8_PARITY_EN
    logic              parity;

    modport master (
        output in_valid, A, B,
        input  Z, out_valid, zero, ones, parity
    );

    modport slave (
        input  in_valid, A, B,
        output Z, out_valid, zero, ones, parity
    );
`else
    modport master (
        output in_valid, A, B,
        input  Z, out_valid, zero, ones
    );

    modport slave (
        input  in_valid, A, B,
        output Z, out_valid, zero, ones
    );
`endif
endinterface

// File: rtl/xor8.sv
// Bitwise XOR of two operands with popcount and zero flag, registered or
// combinational per REG_OUT; macro XOR8_PARITY_EN adds a parity output.
module xor8 #(
    parameter int WIDTH   = 8,
    parameter bit REG_OUT = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    xor8_if.slave  bus
);
    localparam int ONES_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  z_d;
    logic [ONES_W-1:0] ones_d;

    function automatic logic [ONES_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [ONES_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + ONES_W'(v[i]);
        end
        return cnt;
    endfunction

    assign z_d    = bus.A ^ bus.B;
    assign ones_d = popcount(z_d);

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0]  z_q;
        logic [ONES_W-1:0] ones_q;
        logic              outValid_q;
`ifdef XOR8_PARITY_EN
        logic              parity_q;
`endif

        // Results load only on valid edges and otherwise hold; out_valid
        // tracks in_valid so idle edges clear it without touching the data.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                z_q        <= '0;
                ones_q     <= '0;
                outValid_q <= 1'b0;
`ifdef XOR8_PARITY_EN
                parity_q   <= 1'b0;
`endif
            end else begin
                outValid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    z_q      <= z_d;
                    ones_q   <= ones_d;
`ifdef XOR8_PARITY_EN
                    parity_q <= ^z_d;
`endif
                end
            end
        end

        assign bus.Z         = z_q;
        assign bus.ones      = ones_q;
        assign bus.out_valid = outValid_q;
        assign bus.zero      = outValid_q && (z_q == '0);
`ifdef XOR8_PARITY_EN
        assign bus.parity    = parity_q;
`endif
    end else begin : g_comb
        assign bus.Z         = z_d;
        assign bus.ones      = ones_d;
        assign bus.out_valid = bus.in_valid;
        assign bus.zero      = bus.in_valid && (z_d == '0);
`ifdef XOR8_PARITY_EN
        assign bus.parity    = ^z_d;
`endif
    end
endmodule

// File: tb/tb_xor8.sv
// Self-checking bench for xor8: drives a registered and a combinational
// instance with the same operands; honours XOR8_PARITY_EN.
module tb_xor8;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    xor8_if #(.WIDTH(8)) busR ();
    xor8_if #(.WIDTH(8)) busC ();

    xor8 #(.WIDTH(8), .REG_OUT(1'b1)) dutR (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busR.slave)
    );

    xor8 #(.WIDTH(8), .REG_OUT(1'b0)) dutC (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busC.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b);
        busR.in_valid = v;
        busR.A        = a;
        busR.B        = b;
        busC.in_valid = v;
        busC.A        = a;
        busC.B        = b;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReg(input string tag, input logic [7:0] z, input int ones,
                            input logic zero, input logic par, input logic ov);
        checkOutput({tag, ".reg.Z"}, 64'(busR.Z), 64'(z));
        checkOutput({tag, ".reg.ones"}, 64'(busR.ones), 64'(ones));
        checkOutput({tag, ".reg.zero"}, 64'(busR.zero), 64'(zero));
        checkOutput({tag, ".reg.out_valid"}, 64'(busR.out_valid), 64'(ov));
`ifdef XOR8_PARITY_EN
        checkOutput({tag, ".reg.parity"}, 64'(busR.parity), 64'(par));
`else
        if (par !== par) $display("[TB] unreachable");
`endif
    endtask

    task automatic checkComb(input string tag, input logic [7:0] z, input int ones,
                             input logic zero, input logic par, input logic ov);
        checkOutput({tag, ".comb.out_valid"}, 64'(busC.out_valid), 64'(ov));
        checkOutput({tag, ".comb.zero"}, 64'(busC.zero), 64'(zero));
        if (ov) begin
            checkOutput({tag, ".comb.Z"}, 64'(busC.Z), 64'(z));
            checkOutput({tag, ".comb.ones"}, 64'(busC.ones), 64'(ones));
`ifdef XOR8_PARITY_EN
            checkOutput({tag, ".comb.parity"}, 64'(busC.parity), 64'(par));
`else
            if (par !== par) $display("[TB] unreachable");
`endif
        end
    endtask

    initial begin
        logic [7:0] mZ;
        int         mOnes;
        logic       mPar;
        logic       mValid;
        logic       v;
        logic [7:0] a;
        logic [7:0] b;

        checks   = 0;
        failures = 0;

        rst_n = 1'b0;
        applyStimulus(1'b1, 8'hFF, 8'h00);
        checkComb("rstComb", 8'hFF, 8, 1'b0, 1'b0, 1'b1);
        stepClock();
        checkReg("rst1", 8'h00, 0, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkReg("rst2", 8'h00, 0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        applyStimulus(1'b1, 8'b1111_0000, 8'b1100_1100);
        checkComb("basic", 8'b0011_1100, 4, 1'b0, 1'b0, 1'b1);
        stepClock();
        checkReg("basic", 8'b0011_1100, 4, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 8'hA5, 8'hA5);
        checkComb("equal", 8'h00, 0, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkReg("equal", 8'h00, 0, 1'b1, 1'b0, 1'b1);

        applyStimulus(1'b1, 8'h5A, 8'hA5);
        checkComb("compl", 8'hFF, 8, 1'b0, 1'b0, 1'b1);
        stepClock();
        checkReg("compl", 8'hFF, 8, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 8'h01, 8'h00);
        checkComb("single", 8'h01, 1, 1'b0, 1'b1, 1'b1);
        stepClock();
        checkReg("single", 8'h01, 1, 1'b0, 1'b1, 1'b1);

        // Back-to-back stream followed by idle edges with unknown operands.
        applyStimulus(1'b1, 8'h00, 8'hFF);
        stepClock();
        checkReg("stream0", 8'hFF, 8, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h0F, 8'hF0);
        stepClock();
        checkReg("stream1", 8'hFF, 8, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h81, 8'h81);
        stepClock();
        checkReg("stream2", 8'h00, 0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hxx, 8'hxx);
        checkComb("idleComb", 8'h00, 0, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkReg("hold1", 8'h00, 0, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkReg("hold2", 8'h00, 0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 8'h3C, 8'h00);
        stepClock();
        applyStimulus(1'b0, 8'hxx, 8'hxx);
        stepClock();
        checkReg("holdNonZero", 8'h3C, 4, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0;
        applyStimulus(1'b1, 8'hFF, 8'h00);
        stepClock();
        checkReg("rstPriority", 8'h00, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'hC3, 8'h01);
        stepClock();
        checkReg("firstAfterRst", 8'hC2, 3, 1'b0, 1'b1, 1'b1);

        mZ     = 8'hC2;
        mOnes  = 3;
        mPar   = 1'b1;
        mValid = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            v = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            if (v) begin
                applyStimulus(1'b1, a, b);
                checkComb("rand", a ^ b, $countones(a ^ b), (a == b), ^(a ^ b), 1'b1);
                mZ    = a ^ b;
                mOnes = $countones(mZ);
                mPar  = ^mZ;
            end else begin
                applyStimulus(1'b0, 8'hxx, 8'hxx);
                checkComb("rand", 8'h00, 0, 1'b0, 1'b0, 1'b0);
            end
            mValid = v;
            stepClock();
            checkReg("rand", mZ, mOnes, mValid && (mZ == 8'h00), mPar, mValid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
